core_stage_sequencer: RTL and testbench
=======================================

// Module: core_stage_sequencer
// PURPOSE
//  Parametrised successor to the core stage FSM. Sequences the multi-cycle RV32 datapath with one-hot stage strobes.
//  Adds memory wait-state handshake with timeout, NUM_IRQ prioritised external IRQs, debug halt and double-fault lockup.
//  Sits in core: drives stage_active, control_op and fault_num into PC, memory, decode, register file, ALU and CSR.
// PARAMETERS
//  NUM_IRQ   4   number of external interrupt lines (>=1); IRQ_W = max(1,$clog2(NUM_IRQ))
//  MAX_WAIT  15  max consecutive mem_ready=0 cycles tolerated in FETCH/MEMORY (>=1); counter width $clog2(MAX_WAIT+1)
// PORTS
//  clk           in   1        clock; all state on rising edge
//  reset         in   1        asynchronous, active-high reset
//  skip_read     in   1        decoded instr has no READ stage
//  has_mem       in   1        decoded instr has MEMORY stage
//  is_store      in   1        MEMORY access is a store (selects fault code)
//  op_fault      in   1        decode/ALU/CSR/illegal-op fault, valid in current stage
//  mem_addr_fault in  1        misaligned access in FETCH/MEMORY
//  mem_acc_fault in   1        access fault in FETCH/MEMORY
//  mem_ready     in   1        memory completes FETCH/MEMORY access this cycle
//  irq_pending   in   NUM_IRQ  external interrupt requests, already masked by CSR enables
//  sw_irq        in   1        software interrupt pending, masked
//  halt_req      in   1        debug halt request
//  stage_active  out  7        one-hot [0]FETCH [1]DECODE [2]READ [3]EXECUTE [4]MEMORY [5]WRITE_BACK [6]UPDATE_PC; 0 in HALT/LOCKUP
//  control_op    out  2        11 normal, 00 trap, 01 ext int, 10 sw int
//  fault_num     out  3        mcause code of current trap
//  irq_id        out  IRQ_W    index of serviced ext IRQ
//  retire        out  1        1-cycle pulse when a normal instr leaves UPDATE_PC
//  halted        out  1        in HALT
//  locked        out  1        in LOCKUP
// BEHAVIOUR
//  Reset (async): state FETCH, control_op=11, fault_num=0, irq_id=0, retire=0, halted=0, locked=0, wait counter=0.
//  Reset mid-operation aborts any stage immediately. First FETCH strobe is in the first cycle after reset deasserts.
//  Normal path: FETCH>DECODE>READ>EXECUTE>MEMORY>WRITE_BACK>UPDATE_PC>(next).
//   DECODE, READ, EXECUTE, WRITE_BACK and UPDATE_PC each take 1 cycle. READ skipped if skip_read. MEMORY skipped if !has_mem.
//  FETCH/MEMORY hold while mem_ready=0. They advance in a cycle with mem_ready=1.
//   Wait counter increments per stalled cycle and clears on stage exit.
//   When the counter reaches MAX_WAIT with mem_ready still 0, the cycle is treated as mem_acc_fault (timeout).
//  Fault codes: FETCH addr=0, FETCH acc/timeout=1, op_fault (any stage)=2, MEMORY addr = is_store?6:4,
//   MEMORY acc/timeout = is_store?7:5. If several faults occur in one cycle, the addr fault beats the acc fault, which beats op_fault.
//   Fault flags are sampled only in the active stage.
//  Fault with control_op=11: next state DECODE, control_op<=00, fault_num latched, no retire.
//  Fault with control_op!=11 (double fault): next state LOCKUP, locked=1. Only reset exits LOCKUP.
//  Trap/int sequence: starts at DECODE (FETCH skipped; core injects ECALL) and runs through UPDATE_PC.
//   On UPDATE_PC exit control_op<=11. retire is not pulsed.
//  At UPDATE_PC exit, priority order:
//   1. halt_req: go to HALT.
//   2. any irq_pending: go to DECODE, control_op=01, irq_id=lowest set index.
//   3. sw_irq: go to DECODE, control_op=10.
//   4. otherwise go to FETCH.
//   IRQ inputs are sampled only at this boundary. Instructions are never interrupted mid-sequence.
//  HALT: stage_active=0, halted=1. Leaves to FETCH in the cycle after halt_req=0. Pending IRQs are re-evaluated at the next UPDATE_PC.
//  control_op, fault_num and irq_id hold stable for the whole trap sequence. fault_num keeps its last value otherwise.
//  Exactly one stage_active bit is set in every non-HALT/non-LOCKUP cycle.
// TESTING
//  1. Reset, mem_ready=1, skip_read=0, has_mem=0 -> FETCH,DECODE,READ,EXECUTE,WRITE_BACK,UPDATE_PC (6 cycles); retire pulses once.
//  2. Load, mem_ready low 3 cycles in MEMORY -> MEMORY active 4 cycles, then WRITE_BACK; no fault.
//  3. mem_ready held 0 in MEMORY, is_store=1, MAX_WAIT=15 -> after 15 stall cycles: DECODE, control_op=00, fault_num=7.
//  4. irq_pending=4'b0110 at UPDATE_PC -> DECODE, control_op=01, irq_id=1; next UPDATE_PC exit gives control_op=11.
//  5. halt_req=1 with irq_pending=1 at UPDATE_PC -> HALT, halted=1; drop halt_req -> FETCH, IRQ serviced at the following UPDATE_PC.
//  6. op_fault during a trap sequence -> LOCKUP, locked=1, stage_active=0; async reset pulse -> FETCH, control_op=11.

Source files
------------

// File: rtl/core_stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and the rest of the core.
// The master side is the datapath/memory/interrupt logic; the slave side is the sequencer.
interface core_stage_sequencer_if #(
  parameter int NUM_IRQ = 4
);
  localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic               skip_read;
  logic               has_mem;
  logic               is_store;
  logic               op_fault;
  logic               mem_addr_fault;
  logic               mem_acc_fault;
  logic               mem_ready;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               sw_irq;
  logic               halt_req;

  logic [6:0]         stage_active;
  logic [1:0]         control_op;
  logic [2:0]         fault_num;
  logic [IRQ_W-1:0]   irq_id;
  logic               retire;
  logic               halted;
  logic               locked;

  modport master (
    output skip_read, has_mem, is_store, op_fault, mem_addr_fault, mem_acc_fault,
           mem_ready, irq_pending, sw_irq, halt_req,
    input  stage_active, control_op, fault_num, irq_id, retire, halted, locked
  );

  modport slave (
    input  skip_read, has_mem, is_store, op_fault, mem_addr_fault, mem_acc_fault,
           mem_ready, irq_pending, sw_irq, halt_req,
    output stage_active, control_op, fault_num, irq_id, retire, halted, locked
  );
endinterface

// File: rtl/core_stage_sequencer.sv
// Multi-cycle RV32 stage sequencer: one-hot stage strobes, memory wait states with
// timeout, prioritised interrupts, debug halt and double-fault lockup.
module core_stage_sequencer #(
  parameter int NUM_IRQ  = 4,
  parameter int MAX_WAIT = 15
) (
  input logic                   clk,
  input logic                   reset,
  core_stage_sequencer_if.slave seq
);
  localparam int IRQ_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXECUTE,
    S_MEMORY,
    S_WRITE_BACK,
    S_UPDATE_PC,
    S_HALT,
    S_LOCKUP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stage;
  logic              stage_live;
  logic              timeout;
  logic              addr_hit;
  logic              acc_hit;
  logic              fault_hit;
  logic              stalled;
  logic [2:0]        fault_code;
  logic [IRQ_W-1:0]  irq_low;
  logic              irq_any;

  function automatic logic [6:0] stage_onehot(input state_t s);
    case (s)
      S_FETCH:      return 7'b0000001;
      S_DECODE:     return 7'b0000010;
      S_READ:       return 7'b0000100;
      S_EXECUTE:    return 7'b0001000;
      S_MEMORY:     return 7'b0010000;
      S_WRITE_BACK: return 7'b0100000;
      S_UPDATE_PC:  return 7'b1000000;
      default:      return 7'b0000000;
    endcase
  endfunction

  // Fault detection: memory faults only count in FETCH/MEMORY, and a stall that has
  // already used up MAX_WAIT cycles is promoted to an access fault.
  always_comb begin
    mem_stage  = (state == S_FETCH) || (state == S_MEMORY);
    stage_live = (state != S_HALT) && (state != S_LOCKUP);
    timeout    = mem_stage && !seq.mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));
    addr_hit   = mem_stage && seq.mem_addr_fault;
    acc_hit    = mem_stage && (seq.mem_acc_fault || timeout);
    fault_hit  = addr_hit || acc_hit || (stage_live && seq.op_fault);
    stalled    = mem_stage && !seq.mem_ready && !fault_hit;
    if (addr_hit)
      fault_code = (state == S_FETCH) ? 3'd0 : (seq.is_store ? 3'd6 : 3'd4);
    else if (acc_hit)
      fault_code = (state == S_FETCH) ? 3'd1 : (seq.is_store ? 3'd7 : 3'd5);
    else
      fault_code = 3'd2;
  end

  always_comb begin
    irq_low = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (seq.irq_pending[i]) irq_low = IRQ_W'(i);
    irq_any = |seq.irq_pending;
  end

  // Trap and interrupt sequences re-enter at DECODE so the core can inject its ECALL.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:      next_state = seq.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:     next_state = seq.skip_read ? S_EXECUTE : S_READ;
      S_READ:       next_state = S_EXECUTE;
      S_EXECUTE:    next_state = seq.has_mem ? S_MEMORY : S_WRITE_BACK;
      S_MEMORY:     next_state = seq.mem_ready ? S_WRITE_BACK : S_MEMORY;
      S_WRITE_BACK: next_state = S_UPDATE_PC;
      S_UPDATE_PC: begin
        if (seq.halt_req)               next_state = S_HALT;
        else if (irq_any || seq.sw_irq) next_state = S_DECODE;
        else                            next_state = S_FETCH;
      end
      S_HALT:       next_state = seq.halt_req ? S_HALT : S_FETCH;
      S_LOCKUP:     next_state = S_LOCKUP;
      default:      next_state = S_FETCH;
    endcase
    if (fault_hit)
      next_state = (seq.control_op == 2'b11) ? S_DECODE : S_LOCKUP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_FETCH;
      wait_cnt         <= '0;
      seq.stage_active <= 7'b0000001;
      seq.control_op   <= 2'b11;
      seq.fault_num    <= 3'd0;
      seq.irq_id       <= '0;
      seq.retire       <= 1'b0;
      seq.halted       <= 1'b0;
      seq.locked       <= 1'b0;
    end else begin
      state            <= next_state;
      wait_cnt         <= stalled ? wait_cnt + WAIT_W'(1) : '0;
      seq.stage_active <= stage_onehot(next_state);
      seq.halted       <= (next_state == S_HALT);
      seq.locked       <= (next_state == S_LOCKUP);
      seq.retire       <= (state == S_UPDATE_PC) && !fault_hit && (seq.control_op == 2'b11);
      if (fault_hit) begin
        if (seq.control_op == 2'b11) begin
          seq.control_op <= 2'b00;
          seq.fault_num  <= fault_code;
        end
      end else if (state == S_UPDATE_PC) begin
        if (!seq.halt_req && irq_any) begin
          seq.control_op <= 2'b01;
          seq.irq_id     <= irq_low;
        end else if (!seq.halt_req && seq.sw_irq) begin
          seq.control_op <= 2'b10;
        end else begin
          seq.control_op <= 2'b11;
        end
      end
    end
  end
endmodule

// File: tb/tb_core_stage_sequencer.sv
// Scoreboard bench for core_stage_sequencer: instruction-level model pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_core_stage_sequencer;
  localparam int NUM_IRQ  = 4;
  localparam int MAX_WAIT = 15;
  localparam int IRQ_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef struct packed {
    logic [6:0]       stage;
    logic [1:0]       ctl;
    logic [2:0]       fnum;
    logic [IRQ_W-1:0] iid;
    logic             retire;
    logic             halted;
    logic             locked;
  } exp_t;

  typedef struct {
    bit               sr;
    bit               hm;
    bit               st;
    int               fst;
    int               mst;
    int               op_stage;
    int               mflt;
    int               mwhere;
    logic [NUM_IRQ-1:0] irq;
    bit               sw;
    bit               hlt;
    int               hcyc;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mon_cyc = 0;
  exp_t sb[$];

  logic [1:0]       m_ctl;
  logic [2:0]       m_fnum;
  logic [IRQ_W-1:0] m_iid;
  bit               m_ret;
  bit               m_lock;

  core_stage_sequencer_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  core_stage_sequencer #(.NUM_IRQ(NUM_IRQ), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .seq   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, mon_cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      mon_cyc++;
      check_output("stage_active", int'(bus.stage_active), int'(e.stage));
      check_output("control_op", int'(bus.control_op), int'(e.ctl));
      check_output("fault_num", int'(bus.fault_num), int'(e.fnum));
      check_output("irq_id", int'(bus.irq_id), int'(e.iid));
      check_output("retire", int'(bus.retire), int'(e.retire));
      check_output("halted", int'(bus.halted), int'(e.halted));
      check_output("locked", int'(bus.locked), int'(e.locked));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [IRQ_W-1:0] lowest(input logic [NUM_IRQ-1:0] v);
    for (int i = 0; i < NUM_IRQ; i++)
      if (v[i]) return IRQ_W'(i);
    return '0;
  endfunction

  // pos: 0..6 = stage index, 7 = HALT, 8 = LOCKUP
  task automatic push_snap(input int pos);
    exp_t e;
    e.stage  = (pos < 7) ? 7'(1 << pos) : 7'd0;
    e.ctl    = m_ctl;
    e.fnum   = m_fnum;
    e.iid    = m_iid;
    e.retire = m_ret;
    e.halted = (pos == 7);
    e.locked = (pos == 8);
    sb.push_back(e);
    m_ret = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.skip_read = 0; bus.has_mem = 0; bus.is_store = 0; bus.op_fault = 0;
    bus.mem_addr_fault = 0; bus.mem_acc_fault = 0; bus.mem_ready = 1;
    bus.irq_pending = '0; bus.sw_irq = 0; bus.halt_req = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    m_ctl = 2'b11; m_fnum = 3'd0; m_iid = '0; m_ret = 0; m_lock = 0;
    repeat (2) push_snap(0);
    reset = 1'b0;
  endtask

  function automatic instr_t plain_instr();
    instr_t t;
    t.sr = 0; t.hm = 0; t.st = 0; t.fst = 0; t.mst = 0;
    t.op_stage = -1; t.mflt = 0; t.mwhere = -1;
    t.irq = '0; t.sw = 0; t.hlt = 0; t.hcyc = 0;
    return t;
  endfunction

  // Walks one instruction (or trap/interrupt sequence) and predicts every cycle of it.
  task automatic apply_stimulus(input instr_t t);
    int  stages[$];
    int  s;
    int  n;
    int  last;
    int  code;
    bit  trap;
    trap = (m_ctl != 2'b11);
    bus.skip_read = t.sr; bus.has_mem = t.hm; bus.is_store = t.st;
    bus.irq_pending = t.irq; bus.sw_irq = t.sw; bus.halt_req = t.hlt;
    if (!trap) stages.push_back(0);
    stages.push_back(1);
    if (!t.sr) stages.push_back(2);
    stages.push_back(3);
    if (t.hm) stages.push_back(4);
    stages.push_back(5);
    stages.push_back(6);
    foreach (stages[k]) begin
      s = stages[k];
      n = (s == 0) ? t.fst : (s == 4) ? t.mst : 0;
      last = (n > MAX_WAIT) ? MAX_WAIT : n;
      for (int c = 0; c <= last; c++) begin
        bus.mem_ready      = (c >= n);
        bus.mem_addr_fault = (c == last) && (t.mwhere == s) && (t.mflt == 1);
        bus.mem_acc_fault  = (c == last) && (t.mwhere == s) && (t.mflt == 2);
        bus.op_fault       = (c == last) && (t.op_stage == s);
        push_snap(s);
      end
      code = -1;
      if (t.mwhere == s && t.mflt == 1)
        code = (s == 0) ? 0 : (t.st ? 6 : 4);
      else if ((t.mwhere == s && t.mflt == 2) || n > MAX_WAIT)
        code = (s == 0) ? 1 : (t.st ? 7 : 5);
      else if (t.op_stage == s)
        code = 2;
      if (code >= 0) begin
        if (m_ctl == 2'b11) begin
          m_ctl  = 2'b00;
          m_fnum = 3'(code);
        end else begin
          m_lock = 1;
        end
        return;
      end
    end
    bus.op_fault = 0; bus.mem_addr_fault = 0; bus.mem_acc_fault = 0; bus.mem_ready = 1;
    m_ret = !trap;
    m_ctl = 2'b11;
    if (t.hlt) begin
      for (int h = 0; h < t.hcyc; h++) push_snap(7);
      bus.halt_req = 0;
      push_snap(7);
    end else if (|t.irq) begin
      m_ctl = 2'b01;
      m_iid = lowest(t.irq);
    end else if (t.sw) begin
      m_ctl = 2'b10;
    end
  endtask

  task automatic run(input instr_t t);
    apply_stimulus(t);
    if (m_lock) begin
      bus.op_fault = 0; bus.mem_addr_fault = 0; bus.mem_acc_fault = 0;
      repeat ($urandom_range(1, 3)) push_snap(8);
      do_reset();
    end
  endtask

  initial begin
    instr_t t;
    reset = 1'b1;
    clear_inputs();
    m_ctl = 2'b11; m_fnum = 3'd0; m_iid = '0; m_ret = 0; m_lock = 0;
    @(posedge clk);
    #1;
    do_reset();

    t = plain_instr();
    run(t);
    t = plain_instr(); t.hm = 1; t.mst = 3;
    run(t);
    t = plain_instr(); t.hm = 1; t.st = 1; t.mst = MAX_WAIT + 1;
    run(t);
    run(plain_instr());
    t = plain_instr(); t.irq = 4'b0110;
    run(t);
    run(plain_instr());
    run(plain_instr());
    t = plain_instr(); t.irq = 4'b0001; t.hlt = 1; t.hcyc = 2;
    run(t);
    t = plain_instr(); t.irq = 4'b0001;
    run(t);
    run(plain_instr());
    t = plain_instr(); t.op_stage = 0;
    run(t);
    t = plain_instr(); t.op_stage = 3;
    run(t);
    t = plain_instr(); t.fst = MAX_WAIT + 1;
    run(t);
    t = plain_instr(); t.hm = 1; t.mflt = 1; t.mwhere = 4; t.op_stage = 4;
    run(t);

    for (int i = 0; i < 200; i++) begin
      t = plain_instr();
      t.sr  = 1'($urandom_range(0, 1));
      t.hm  = 1'($urandom_range(0, 1));
      t.st  = 1'($urandom_range(0, 1));
      t.fst = ($urandom_range(0, 15) == 0) ? MAX_WAIT + 1 : int'($urandom_range(0, 2));
      t.mst = ($urandom_range(0, 10) == 0) ? MAX_WAIT + 1 : int'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) t.op_stage = int'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) begin
        t.mflt   = int'($urandom_range(1, 2));
        t.mwhere = int'($urandom_range(0, 1)) * 4;
      end
      t.irq  = ($urandom_range(0, 4) == 0) ? NUM_IRQ'($urandom) : '0;
      t.sw   = ($urandom_range(0, 5) == 0);
      t.hlt  = ($urandom_range(0, 7) == 0);
      t.hcyc = int'($urandom_range(0, 3));
      run(t);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
